// File: rtl/hough_peak_reader.sv
// Hough accumulator peak reader: walks every (theta, rho) bin once, reports bins whose
// vote count exceeds a threshold as lines, and optionally zeroes each bin after reading it.
module hough_peak_reader #(
   parameter int RHO_BINS      = 1600,
   parameter int RHO_OFFSET    = 800,
   parameter int THETA_BINS    = 181,
   parameter int VOTE_W        = 16,
   parameter int MAX_LINES     = 16,
   parameter int CLEAR_ON_READ = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [VOTE_W-1:0]        threshold,
   output logic [18:0]              acc_address,
   output logic                     acc_read,
   input  logic [VOTE_W-1:0]        acc_data,
   output logic                     acc_write,
   output logic [VOTE_W-1:0]        acc_wdata,
   output logic                     line_valid,
   input  logic                     line_ready,
   output logic signed [10:0]       line_rho,
   output logic [7:0]               line_theta,
   output logic [VOTE_W-1:0]        line_votes,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [4:0]               line_count
);

   localparam logic [10:0] RHO_LAST   = 11'(RHO_BINS - 1);
   localparam logic [7:0]  THETA_LAST = 8'(THETA_BINS - 1);
   localparam logic [4:0]  MAX_COUNT  = 5'(MAX_LINES);
   localparam logic        CLEAR      = (CLEAR_ON_READ != 0);

   typedef enum logic [2:0] {IDLE, READ, CMP, EMIT, NEXT, DONE} state_t;

   state_t                state_reg;
   logic [VOTE_W-1:0]     threshold_reg;
   logic [10:0]           rho_idx_reg;
   logic [7:0]            theta_reg;
   logic [18:0]           acc_address_reg;
   logic                  acc_read_reg;
   logic                  acc_write_reg;
   logic                  line_valid_reg;
   logic signed [10:0]    line_rho_reg;
   logic [7:0]            line_theta_reg;
   logic [VOTE_W-1:0]     line_votes_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  overflow_reg;
   logic [4:0]            line_count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= IDLE;
         threshold_reg   <= '0;
         rho_idx_reg     <= '0;
         theta_reg       <= '0;
         acc_address_reg <= '0;
         acc_read_reg    <= 1'b0;
         acc_write_reg   <= 1'b0;
         line_valid_reg  <= 1'b0;
         line_rho_reg    <= '0;
         line_theta_reg  <= '0;
         line_votes_reg  <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         overflow_reg    <= 1'b0;
         line_count_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  threshold_reg   <= threshold;
                  rho_idx_reg     <= '0;
                  theta_reg       <= '0;
                  acc_address_reg <= '0;
                  line_count_reg  <= '0;
                  overflow_reg    <= 1'b0;
                  busy_reg        <= 1'b1;
                  acc_read_reg    <= 1'b1;
                  state_reg       <= READ;
               end
            end
            READ: begin
               acc_read_reg <= 1'b0;
               state_reg    <= CMP;
            end
            CMP: begin
               // acc_data now carries the word requested during READ
               if (acc_data > threshold_reg && line_count_reg < MAX_COUNT) begin
                  line_rho_reg   <= $signed(rho_idx_reg - 11'(RHO_OFFSET));
                  line_theta_reg <= theta_reg;
                  line_votes_reg <= acc_data;
                  line_valid_reg <= 1'b1;
                  state_reg      <= EMIT;
               end else begin
                  if (acc_data > threshold_reg)
                     overflow_reg <= 1'b1;
                  acc_write_reg <= CLEAR;
                  state_reg     <= NEXT;
               end
            end
            EMIT: begin
               if (line_ready) begin
                  line_valid_reg <= 1'b0;
                  line_count_reg <= line_count_reg + 5'd1;
                  acc_write_reg  <= CLEAR;
                  state_reg      <= NEXT;
               end
            end
            NEXT: begin
               acc_write_reg <= 1'b0;
               if (theta_reg == THETA_LAST && rho_idx_reg == RHO_LAST) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end else begin
                  if (rho_idx_reg == RHO_LAST) begin
                     rho_idx_reg     <= '0;
                     theta_reg       <= theta_reg + 8'd1;
                     acc_address_reg <= {theta_reg + 8'd1, 11'd0};
                  end else begin
                     rho_idx_reg     <= rho_idx_reg + 11'd1;
                     acc_address_reg <= {theta_reg, rho_idx_reg + 11'd1};
                  end
                  acc_read_reg <= 1'b1;
                  state_reg    <= READ;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign acc_address = acc_address_reg;
   assign acc_read    = acc_read_reg;
   assign acc_write   = acc_write_reg;
   assign acc_wdata   = '0;
   assign line_valid  = line_valid_reg;
   assign line_rho    = line_rho_reg;
   assign line_theta  = line_theta_reg;
   assign line_votes  = line_votes_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign overflow    = overflow_reg;
   assign line_count  = line_count_reg;

endmodule

// File: tb/tb_hough_peak_reader.sv
// Randomized bench for hough_peak_reader on a 3x4 accumulator; a scan-order model predicts
// lines, overflow, line_count and done latency, and a negedge monitor checks every cycle.
module tb_hough_peak_reader;

   localparam int RB = 4;
   localparam int RO = 2;
   localparam int TB = 3;
   localparam int ML = 2;
   localparam int VW = 16;
   localparam int NB = RB * TB;

   typedef struct {int rho; int theta; int votes;} line_t;

   logic                clock;
   logic                reset;
   logic                start;
   logic [VW-1:0]       threshold;
   logic [18:0]         acc_address;
   logic                acc_read;
   logic [VW-1:0]       acc_data;
   logic                acc_write;
   logic [VW-1:0]       acc_wdata;
   logic                line_valid;
   logic                line_ready;
   logic signed [10:0]  line_rho;
   logic [7:0]          line_theta;
   logic [VW-1:0]       line_votes;
   logic                busy;
   logic                done;
   logic                overflow;
   logic [4:0]          line_count;

   hough_peak_reader #(
      .RHO_BINS(RB), .RHO_OFFSET(RO), .THETA_BINS(TB), .VOTE_W(VW),
      .MAX_LINES(ML), .CLEAR_ON_READ(1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .threshold(threshold),
      .acc_address(acc_address), .acc_read(acc_read), .acc_data(acc_data),
      .acc_write(acc_write), .acc_wdata(acc_wdata), .line_valid(line_valid),
      .line_ready(line_ready), .line_rho(line_rho), .line_theta(line_theta),
      .line_votes(line_votes), .busy(busy), .done(done), .overflow(overflow),
      .line_count(line_count)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [VW-1:0] mem [NB];
   logic [VW-1:0] mem_init [NB];
   logic          mem_load = 1'b0;

   line_t exp_q[$];
   line_t got_q[$];
   int    exp_ovf;
   int    exp_lat;
   int    stall_q [ML];

   bit    mon_active = 1'b0;
   bit    scan_done = 1'b0;
   int    start_cyc;
   int    mon_n;
   int    rd_k;
   int    hs;
   int    last_addr;
   int    done_n;
   bit    prev_valid, prev_ready;
   int    prev_rho, prev_theta, prev_votes;
   line_t mon_g;

   bit    drv_in_line = 1'b0;
   int    drv_left = 0;
   int    drv_k = 0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int addr_to_idx(input logic [18:0] a);
      if (int'(a[18:11]) < TB && int'(a[10:0]) < RB)
         return int'(a[18:11]) * RB + int'(a[10:0]);
      return -1;
   endfunction

   function automatic int bin_addr(input int k);
      return ((k / RB) << 11) | (k % RB);
   endfunction

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Accumulator RAM: registered read, one-cycle latency
   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < NB; i++) mem[i] <= mem_init[i];
      end else begin
         if (acc_read)
            acc_data <= (addr_to_idx(acc_address) >= 0) ? mem[addr_to_idx(acc_address)] : 16'hdead;
         if (acc_write && addr_to_idx(acc_address) >= 0)
            mem[addr_to_idx(acc_address)] <= acc_wdata;
      end
   end

   // line_ready: held low for the planned stall of each line, random otherwise
   initial begin
      line_ready = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         if (line_valid) begin
            if (!drv_in_line) begin
               drv_in_line = 1'b1;
               drv_left = (drv_k < ML) ? stall_q[drv_k] : 0;
               drv_k++;
            end
            if (drv_left > 0) begin
               line_ready = 1'b0;
               drv_left--;
            end else begin
               line_ready = 1'b1;
            end
         end else begin
            drv_in_line = 1'b0;
            line_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         mon_active = 1'b0;
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else if (mon_active) begin
         mon_n = cyc - start_cyc;
         check("rw_exclusive", int'(acc_read & acc_write), 0);
         if (mon_n >= 1) check("busy", int'(busy), 1);
         if (acc_read) begin
            check("read_addr", int'(acc_address), bin_addr(rd_k));
            rd_k++;
            last_addr = int'(acc_address);
         end
         if (acc_write) begin
            check("write_addr", int'(acc_address), last_addr);
            check("write_data", int'(acc_wdata), 0);
         end
         if (prev_valid && !prev_ready) begin
            check("valid_hold", int'(line_valid), 1);
            check("rho_hold", int'(line_rho), prev_rho);
            check("theta_hold", int'(line_theta), prev_theta);
            check("votes_hold", int'(line_votes), prev_votes);
         end
         if (line_valid && !prev_valid) begin
            mon_g.rho = int'(line_rho);
            mon_g.theta = int'(line_theta);
            mon_g.votes = int'(line_votes);
            if (got_q.size() < exp_q.size()) begin
               check("line_rho", mon_g.rho, exp_q[got_q.size()].rho);
               check("line_theta", mon_g.theta, exp_q[got_q.size()].theta);
               check("line_votes", mon_g.votes, exp_q[got_q.size()].votes);
            end else begin
               check("extra_line", got_q.size() + 1, exp_q.size());
            end
            got_q.push_back(mon_g);
         end
         if (line_valid && line_ready) hs++;
         if (done) begin
            done_n = mon_n;
            check("done_latency", mon_n, exp_lat);
            check("line_count", int'(line_count), exp_q.size());
            check("overflow", int'(overflow), exp_ovf);
            check("bins_read", rd_k, NB);
            check("handshakes", hs, exp_q.size());
            mon_active = 1'b0;
            scan_done = 1'b1;
         end else if (mon_n > exp_lat + 8) begin
            check("done_timeout", mon_n, exp_lat);
            mon_active = 1'b0;
            scan_done = 1'b1;
         end
         prev_valid = line_valid;
         prev_ready = line_ready;
         prev_rho = int'(line_rho);
         prev_theta = int'(line_theta);
         prev_votes = int'(line_votes);
      end
   end

   // Scan-order reference: first ML bins above threshold become lines, any later hit flags overflow
   task automatic build_model(input int thr);
      exp_q.delete();
      exp_ovf = 0;
      for (int t = 0; t < TB; t++) begin
         for (int r = 0; r < RB; r++) begin
            if (int'(mem_init[t * RB + r]) > thr) begin
               if (exp_q.size() < ML) exp_q.push_back('{r - RO, t, int'(mem_init[t * RB + r])});
               else exp_ovf = 1;
            end
         end
      end
      exp_lat = 3 * NB + 1;
      for (int k = 0; k < exp_q.size(); k++) exp_lat += 1 + stall_q[k];
   endtask

   task automatic load_mem();
      @(posedge clock);
      #2 mem_load = 1'b1;
      @(posedge clock);
      #2 mem_load = 1'b0;
   endtask

   task automatic run_scan(input int thr, input bit poke_start);
      int nz;
      build_model(thr);
      drv_k = 0;
      @(posedge clock);
      #2;
      threshold = 16'(thr);
      start = 1'b1;
      start_cyc = cyc;
      rd_k = 0;
      hs = 0;
      done_n = -1;
      got_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      scan_done = 1'b0;
      mon_active = 1'b1;
      @(posedge clock);
      #2;
      start = 1'b0;
      threshold = 16'($urandom);
      if (poke_start) begin
         repeat (10) @(posedge clock);
         #2;
         start = 1'b1;
         threshold = '0;
         @(posedge clock);
         #2 start = 1'b0;
      end
      for (int i = 0; i < 400 && !scan_done; i++) @(posedge clock);
      if (!scan_done) begin
         check("scan_finished", 0, 1);
         mon_active = 1'b0;
      end
      @(negedge clock);
      check("busy_after_done", int'(busy), 0);
      check("done_single_pulse", int'(done), 0);
      nz = 0;
      for (int i = 0; i < NB; i++) if (mem[i] != '0) nz++;
      check("bins_cleared", nz, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_line_valid", int'(line_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_acc_read", int'(acc_read), 0);
      check("rst_acc_write", int'(acc_write), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_line_count", int'(line_count), 0);
      check("rst_acc_address", int'(acc_address), 0);
      check("rst_line_rho", int'(line_rho), 0);
      check("rst_line_theta", int'(line_theta), 0);
      check("rst_line_votes", int'(line_votes), 0);
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      start = 1'b0;
      threshold = '0;
      for (int i = 0; i < NB; i++) mem_init[i] = '0;
      for (int k = 0; k < ML; k++) stall_q[k] = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      @(posedge clock);
      #2 reset = 1'b0;
      load_mem();

      // all-zero memory, threshold 0
      run_scan(0, 1'b0);
      check("zero_done_at_37", done_n, 37);
      check("zero_no_lines", got_q.size(), 0);

      // single hit at theta 1, rho_idx 3
      mem_init[7] = 16'd9;
      load_mem();
      run_scan(5, 1'b0);
      check("hit_lines", got_q.size(), 1);
      if (got_q.size() == 1) begin
         check("hit_rho_lit", got_q[0].rho, 1);
         check("hit_theta_lit", got_q[0].theta, 1);
         check("hit_votes_lit", got_q[0].votes, 9);
      end
      check("hit_done_at_38", done_n, 38);
      check("hit_count_lit", int'(line_count), 1);

      // same hit with line_ready low for 4 cycles
      load_mem();
      stall_q[0] = 4;
      run_scan(5, 1'b0);
      check("stall_done_at_42", done_n, 42);
      stall_q[0] = 0;

      // three hits, two emitted, overflow flagged
      for (int i = 0; i < NB; i++) mem_init[i] = (i < 3) ? 16'd7 : 16'd0;
      load_mem();
      run_scan(6, 1'b0);
      check("ovf_lines", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("ovf_rho0_lit", got_q[0].rho, -2);
         check("ovf_rho1_lit", got_q[1].rho, -1);
      end
      check("ovf_flag_lit", int'(overflow), 1);
      check("ovf_count_lit", int'(line_count), 2);

      // value equal to threshold is not a line; mid-scan start ignored
      for (int i = 0; i < NB; i++) mem_init[i] = '0;
      mem_init[5] = 16'd5;
      load_mem();
      run_scan(5, 1'b1);
      check("equal_no_line", got_q.size(), 0);

      // reset while a line waits in EMIT
      for (int i = 0; i < NB; i++) mem_init[i] = '0;
      mem_init[7] = 16'd9;
      load_mem();
      stall_q[0] = 50;
      drv_k = 0;
      @(posedge clock);
      #2;
      threshold = 16'd5;
      start = 1'b1;
      @(posedge clock);
      #2 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clock);
         #2 seen = line_valid;
      end
      check("emit_reached", int'(seen), 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      check("pending_bin_kept", int'(mem[7]), 9);
      @(posedge clock);
      #2 reset = 1'b0;
      stall_q[0] = 0;
      run_scan(5, 1'b0);
      check("rescan_lines", got_q.size(), 1);

      // randomized scans
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < NB; i++)
            mem_init[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'd0;
         for (int k = 0; k < ML; k++) stall_q[k] = $urandom_range(0, 3);
         load_mem();
         run_scan($urandom_range(0, 8), 1'(it % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
